layer_0_maxpool: RTL and testbench

Streaming 2x2 max-pool with stride 2, placed directly downstream of the layer-0 feature-map stage of the YOLOv3-Tiny datapath. It consumes one IEEE-754 single-precision feature-map pixel per valid cycle, in raster order. It emits one pooled pixel per 2x2 window, halving each spatial dimension (416x416 -> 208x208). Each instance handles one feature-map channel.

---
 rtl/layer_0_maxpool_if.sv | 20 ++
 rtl/layer_0_maxpool.sv | 111 +++++++++++
 tb/tb_layer_0_maxpool.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/layer_0_maxpool_if.sv
// Pixel stream bundle for the layer-0 max-pool.
// The master drives pixels in and takes pooled pixels out.
interface layer_0_maxpool_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] data_in;
  logic                  valid_in;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  valid_out;

  modport master (
    output data_in, valid_in,
    input  data_out, valid_out
  );

  modport slave (
    input  data_in, valid_in,
    output data_out, valid_out
  );
endinterface

// File: rtl/layer_0_maxpool.sv
// Streaming 2x2 / stride-2 max-pool over IEEE-754 single pixels.
// One channel per instance; raster-order input, raster-order output.
module layer_0_maxpool #(
  parameter int DATA_WIDTH = 32,
  parameter int IMG_SIZE   = 416
) (
  input logic              Clk,
  input logic              Rst,
  layer_0_maxpool_if.slave bus
);
  localparam int CW   = (IMG_SIZE > 2) ? $clog2(IMG_SIZE) : 1;
  localparam int HALF = IMG_SIZE / 2;
  localparam int LW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [CW-1:0] LAST = CW'(IMG_SIZE - 1);

  typedef enum logic {
    ROW_EVEN,
    ROW_ODD
  } phase_e;

  phase_e state_q, state_d;

  logic [CW-1:0]         col_q, col_d;
  logic [CW-1:0]         row_q, row_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] pair_q;
  logic [DATA_WIDTH-1:0] line_buf [HALF];

  logic [LW-1:0]         idx;
  logic [DATA_WIDTH-1:0] lb_rd;
  logic [DATA_WIDTH-1:0] m;
  logic                  lb_we;
  logic                  pair_we;

  // Sign-magnitude float mapped to an unsigned key with the same order.
  function automatic logic [DATA_WIDTH-1:0] fkey(
    input logic [DATA_WIDTH-1:0] x
  );
    if (x[DATA_WIDTH-1])
      return {1'b0, ~x[DATA_WIDTH-2:0]};
    else
      return {1'b1, x[DATA_WIDTH-2:0]};
  endfunction

  function automatic logic [DATA_WIDTH-1:0] fmax(
    input logic [DATA_WIDTH-1:0] a,
    input logic [DATA_WIDTH-1:0] b
  );
    return (fkey(b) > fkey(a)) ? b : a;
  endfunction

  assign idx     = LW'(col_q >> 1);
  assign lb_rd   = line_buf[idx];
  assign m       = fmax(pair_q, bus.data_in);
  assign pair_we = bus.valid_in && !col_q[0];
  assign lb_we   = bus.valid_in && col_q[0]
                && (state_q == ROW_EVEN);

  always_comb begin
    col_d   = col_q;
    row_d   = row_q;
    state_d = state_q;
    data_d  = data_q;
    valid_d = 1'b0;
    if (bus.valid_in) begin
      if (col_q == LAST) begin
        col_d = '0;
        row_d = (row_q == LAST) ? '0 : row_q + 1'b1;
        unique case (state_q)
          ROW_EVEN: state_d = ROW_ODD;
          ROW_ODD:  state_d = ROW_EVEN;
          default:  state_d = ROW_EVEN;
        endcase
      end else begin
        col_d = col_q + 1'b1;
      end
      if (col_q[0] && (state_q == ROW_ODD)) begin
        valid_d = 1'b1;
        data_d  = fmax(lb_rd, m);
      end
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= ROW_EVEN;
      col_q   <= '0;
      row_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  // Datapath storage is always written before being read in a frame.
  always_ff @(posedge Clk) begin
    if (pair_we)
      pair_q <= bus.data_in;
    if (lb_we)
      line_buf[idx] <= m;
  end

  assign bus.data_out  = data_q;
  assign bus.valid_out = valid_q;
endmodule

// File: tb/tb_layer_0_maxpool.sv
// Bench for layer_0_maxpool: directed scenarios plus random frames
// checked against a window-max model built from stored pixels.
module tb_layer_0_maxpool;
  logic        Clk = 1'b0;
  logic        Rst;
  logic [1:0]  sel;
  logic        vld;
  logic [31:0] din;
  logic        obs_v;
  logic [31:0] obs_d;

  always #5 Clk = ~Clk;

  layer_0_maxpool_if #(.DATA_WIDTH(32)) b4 ();
  layer_0_maxpool_if #(.DATA_WIDTH(32)) b2 ();
  layer_0_maxpool_if #(.DATA_WIDTH(32)) b16 ();

  assign b4.data_in   = din;
  assign b2.data_in   = din;
  assign b16.data_in  = din;
  assign b4.valid_in  = vld && (sel == 2'd0);
  assign b2.valid_in  = vld && (sel == 2'd1);
  assign b16.valid_in = vld && (sel == 2'd2);

  layer_0_maxpool #(.DATA_WIDTH(32), .IMG_SIZE(4)) u4 (
    .Clk(Clk), .Rst(Rst), .bus(b4.slave)
  );
  layer_0_maxpool #(.DATA_WIDTH(32), .IMG_SIZE(2)) u2 (
    .Clk(Clk), .Rst(Rst), .bus(b2.slave)
  );
  layer_0_maxpool #(.DATA_WIDTH(32), .IMG_SIZE(16)) u16 (
    .Clk(Clk), .Rst(Rst), .bus(b16.slave)
  );

  always_comb begin
    obs_v = b4.valid_out;
    obs_d = b4.data_out;
    if (sel == 2'd1) begin
      obs_v = b2.valid_out;
      obs_d = b2.data_out;
    end else if (sel == 2'd2) begin
      obs_v = b16.valid_out;
      obs_d = b16.data_out;
    end
  end

  int total = 0;
  int bad   = 0;
  int n;
  int p;
  logic [31:0] pix [16][16];
  logic [31:0] exp_d [3];
  logic [31:0] cap [$];
  logic [31:0] ramp [16] = '{
    32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
    32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000,
    32'h41100000, 32'h41200000, 32'h41300000, 32'h41400000,
    32'h41500000, 32'h41600000, 32'h41700000, 32'h41800000
  };
  logic [31:0] rvals [4] = '{
    32'h40C00000, 32'h41000000, 32'h41600000, 32'h41800000
  };
  logic [31:0] zpool [4] = '{
    32'h00000000, 32'h80000000, 32'h3F800000, 32'hBF800000
  };

  // Larger float by sign and magnitude; +0 beats -0.
  function automatic logic [31:0] fbig(
    input logic [31:0] a,
    input logic [31:0] b
  );
    if (a[31] != b[31])
      return a[31] ? b : a;
    if (!a[31])
      return (a[30:0] >= b[30:0]) ? a : b;
    return (a[30:0] <= b[30:0]) ? a : b;
  endfunction

  task automatic chk(
    input string       tag,
    input logic [31:0] o,
    input logic [31:0] e
  );
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, o, e);
    end
  endtask

  task automatic use_dut(input int s);
    sel = 2'(s);
    n   = (s == 0) ? 4 : (s == 1) ? 2 : 16;
    p   = 0;
    cap.delete();
  endtask

  task automatic step(input logic v, input logic [31:0] d);
    logic ev;
    int r;
    int c;
    ev  = 1'b0;
    vld = v;
    din = d;
    if (v) begin
      r = p / n;
      c = p % n;
      pix[r][c] = d;
      if ((r % 2 == 1) && (c % 2 == 1)) begin
        ev = 1'b1;
        exp_d[sel] = fbig(fbig(fbig(pix[r-1][c-1], pix[r-1][c]),
                                pix[r][c-1]), d);
      end
      p = (p + 1) % (n * n);
    end
    @(posedge Clk);
    #1;
    chk("valid_out", {31'b0, obs_v}, {31'b0, ev});
    chk("data_out", obs_d, exp_d[sel]);
    if (obs_v) cap.push_back(obs_d);
    vld = 1'b0;
  endtask

  task automatic chk_ramp(input string tag);
    chk({tag, "_count"}, 32'(cap.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      chk(tag, (i < cap.size()) ? cap[i] : 32'hDEADBEEF, rvals[i]);
  endtask

  initial begin
    logic [31:0] rv;
    Rst = 1'b1;
    vld = 1'b0;
    din = '0;
    sel = 2'd0;
    n   = 4;
    p   = 0;
    for (int i = 0; i < 3; i++) exp_d[i] = '0;
    #12;
    chk("rst_v4", {31'b0, b4.valid_out}, 32'd0);
    chk("rst_d4", b4.data_out, 32'd0);
    chk("rst_v2", {31'b0, b2.valid_out}, 32'd0);
    chk("rst_d16", b16.data_out, 32'd0);
    @(posedge Clk);
    #1;
    Rst = 1'b0;

    use_dut(0);
    for (int i = 0; i < 16; i++) step(1'b1, ramp[i]);
    step(1'b0, 32'h12345678);
    chk_ramp("ramp");

    use_dut(1);
    step(1'b1, 32'hBF800000);
    step(1'b1, 32'hC0000000);
    step(1'b1, 32'hBF000000);
    step(1'b1, 32'hC0400000);
    chk("neg_win", cap.size() > 0 ? cap[0] : 32'hDEADBEEF,
        32'hBF000000);
    cap.delete();
    step(1'b1, 32'h80000000);
    step(1'b1, 32'h00000000);
    step(1'b1, 32'hBF800000);
    step(1'b1, 32'hC0000000);
    step(1'b1, 32'h00000000);
    step(1'b1, 32'h80000000);
    step(1'b1, 32'hBF800000);
    step(1'b1, 32'hC0000000);
    chk("zero_a", cap.size() > 0 ? cap[0] : 32'hDEADBEEF, 32'h0);
    chk("zero_b", cap.size() > 1 ? cap[1] : 32'hDEADBEEF, 32'h0);

    use_dut(0);
    for (int i = 0; i < 16; i++) begin
      repeat ($urandom_range(0, 3)) step(1'b0, $urandom);
      step(1'b1, ramp[i]);
    end
    step(1'b0, $urandom);
    chk_ramp("gaps");

    use_dut(0);
    for (int i = 0; i < 6; i++) step(1'b1, ramp[i]);
    Rst = 1'b1;
    #1;
    chk("mid_rst_v", {31'b0, b4.valid_out}, 32'd0);
    chk("mid_rst_d", b4.data_out, 32'd0);
    @(posedge Clk);
    #1;
    chk("mid_rst_hold", {31'b0, b4.valid_out}, 32'd0);
    Rst = 1'b0;
    for (int i = 0; i < 3; i++) exp_d[i] = '0;
    use_dut(0);
    step(1'b0, $urandom);
    for (int i = 0; i < 16; i++) step(1'b1, ramp[i]);
    step(1'b0, $urandom);
    chk_ramp("after_rst");

    use_dut(2);
    for (int i = 0; i < 512; i++) begin
      rv = $urandom;
      if ($urandom_range(0, 4) == 0) rv = zpool[$urandom_range(0, 3)];
      step(1'b1, rv);
    end
    step(1'b0, $urandom);
    chk("rand_count", 32'(cap.size()), 32'd128);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
